// File: rtl/sym_timing_search_ctrl.sv
// Receive-timing alignment controller: sweeps (sym_delay, sam_delay) candidates, measures the
// accumulated squared slicer error at each one and locks the pair with the minimum error.
module sym_timing_search_ctrl #(
  parameter logic [7:0] SYM_DELAY_MIN = 8'd34,
  parameter logic [7:0] SYM_DELAY_MAX = 8'd42,
  parameter logic [7:0] DATA_OFFSET   = 8'd14,
  parameter logic [3:0] SETTLE_CYCLES = 4'd2,
  parameter logic [1:0] DEF_SAM       = 2'd1,
  parameter logic [7:0] DEF_SYM       = 8'd38
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_sym_clk_en,
  input  logic        i_cycle_done,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [17:0] i_acc_sq_err,
  output logic [1:0]  o_sam_delay,
  output logic [7:0]  o_sym_delay,
  output logic [7:0]  o_data_delay,
  output logic [17:0] o_best_err,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_locked
);

  typedef enum logic [2:0] {StIdle, StApply, StSettle, StMeasure, StCompare, StFinish} state_t;

  state_t      r_state;
  logic [1:0]  r_cur_sam, r_best_sam, r_sam_delay;
  logic [7:0]  r_cur_sym, r_best_sym, r_sym_delay, r_data_delay;
  logic [17:0] r_best_err;
  logic [3:0]  r_settle_cnt;
  logic        r_first, r_busy, r_done, r_locked;

  logic        w_event, w_better, w_last;
  logic [1:0]  w_win_sam;
  logic [7:0]  w_win_sym;

  assign w_event   = i_cycle_done & i_sym_clk_en;
  // Strict less-than keeps the earlier point on ties.
  assign w_better  = r_first | (i_acc_sq_err < r_best_err);
  assign w_last    = (r_cur_sym == SYM_DELAY_MAX) && (r_cur_sam == 2'd3);
  assign w_win_sam = w_better ? r_cur_sam : r_best_sam;
  assign w_win_sym = w_better ? r_cur_sym : r_best_sym;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_cur_sam    <= 2'd0;
      r_cur_sym    <= SYM_DELAY_MIN;
      r_best_sam   <= DEF_SAM;
      r_best_sym   <= DEF_SYM;
      r_sam_delay  <= DEF_SAM;
      r_sym_delay  <= DEF_SYM;
      r_data_delay <= DEF_SYM + DATA_OFFSET;
      r_best_err   <= 18'h3FFFF;
      r_settle_cnt <= 4'd0;
      r_first      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_abort && (r_state != StIdle)) begin
        r_state      <= StIdle;
        r_sam_delay  <= DEF_SAM;
        r_sym_delay  <= DEF_SYM;
        r_data_delay <= DEF_SYM + DATA_OFFSET;
        r_busy       <= 1'b0;
        r_locked     <= 1'b0;
      end else begin
        case (r_state)
          StIdle: begin
            if (i_start) begin
              r_state      <= StApply;
              r_cur_sam    <= 2'd0;
              r_cur_sym    <= SYM_DELAY_MIN;
              r_sam_delay  <= 2'd0;
              r_sym_delay  <= SYM_DELAY_MIN;
              r_data_delay <= SYM_DELAY_MIN + DATA_OFFSET;
              r_first      <= 1'b1;
              r_busy       <= 1'b1;
              r_locked     <= 1'b0;
            end
          end
          StApply: begin
            r_settle_cnt <= 4'd0;
            r_state      <= (SETTLE_CYCLES == 4'd0) ? StMeasure : StSettle;
          end
          StSettle: begin
            if (w_event) begin
              if (r_settle_cnt == SETTLE_CYCLES - 4'd1) r_state <= StMeasure;
              else r_settle_cnt <= r_settle_cnt + 4'd1;
            end
          end
          StMeasure: begin
            if (w_event) r_state <= StCompare;
          end
          StCompare: begin
            r_first <= 1'b0;
            if (w_better) begin
              r_best_err <= i_acc_sq_err;
              r_best_sam <= r_cur_sam;
              r_best_sym <= r_cur_sym;
            end
            if (w_last) begin
              // Final pair is applied on entry to StFinish so it is valid while done is high.
              r_state      <= StFinish;
              r_sam_delay  <= w_win_sam;
              r_sym_delay  <= w_win_sym;
              r_data_delay <= w_win_sym + DATA_OFFSET;
              r_done       <= 1'b1;
              r_locked     <= 1'b1;
              r_busy       <= 1'b0;
            end else begin
              r_state <= StApply;
              if (r_cur_sam == 2'd3) begin
                r_cur_sam    <= 2'd0;
                r_cur_sym    <= r_cur_sym + 8'd1;
                r_sam_delay  <= 2'd0;
                r_sym_delay  <= r_cur_sym + 8'd1;
                r_data_delay <= r_cur_sym + 8'd1 + DATA_OFFSET;
              end else begin
                r_cur_sam   <= r_cur_sam + 2'd1;
                r_sam_delay <= r_cur_sam + 2'd1;
              end
            end
          end
          StFinish: r_state <= StIdle;
          default:  r_state <= StIdle;
        endcase
      end
    end
  end

  assign o_sam_delay  = r_sam_delay;
  assign o_sym_delay  = r_sym_delay;
  assign o_data_delay = r_data_delay;
  assign o_best_err   = r_best_err;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_locked     = r_locked;

endmodule

// File: tb/tb_sym_timing_search_ctrl.sv
// Bench for sym_timing_search_ctrl: table-driven full sweeps plus abort, reset and event-gating
// sequences against hand-computed results.
module tb_sym_timing_search_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sym_clk_en = 1'b1;
  logic        cycle_done = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic        start0 = 1'b0, abort0 = 1'b0;
  logic [17:0] acc;
  logic [1:0]  sam, sam0;
  logic [7:0]  sym, sym0, dat, dat0;
  logic [17:0] best, best0;
  logic        busy, done, locked, busy0, done0, locked0;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int mode = 0;
  logic [1:0]  s_sam;
  logic [7:0]  s_sym, s_dat;
  logic [17:0] s_best;
  logic        s_busy, s_locked;

  always #5 clk = ~clk;

  sym_timing_search_ctrl #(
    .SYM_DELAY_MIN(8'd36), .SYM_DELAY_MAX(8'd38), .DATA_OFFSET(8'd14),
    .SETTLE_CYCLES(4'd1), .DEF_SAM(2'd1), .DEF_SYM(8'd38)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_sym_clk_en(sym_clk_en), .i_cycle_done(cycle_done),
    .i_start(start), .i_abort(abort), .i_acc_sq_err(acc),
    .o_sam_delay(sam), .o_sym_delay(sym), .o_data_delay(dat), .o_best_err(best),
    .o_busy(busy), .o_done(done), .o_locked(locked)
  );

  sym_timing_search_ctrl #(
    .SYM_DELAY_MIN(8'd36), .SYM_DELAY_MAX(8'd36), .DATA_OFFSET(8'd14),
    .SETTLE_CYCLES(4'd0), .DEF_SAM(2'd1), .DEF_SYM(8'd38)
  ) dut0 (
    .i_clk(clk), .i_reset(reset), .i_sym_clk_en(sym_clk_en), .i_cycle_done(cycle_done),
    .i_start(start0), .i_abort(abort0), .i_acc_sq_err(acc),
    .o_sam_delay(sam0), .o_sym_delay(sym0), .o_data_delay(dat0), .o_best_err(best0),
    .o_busy(busy0), .o_done(done0), .o_locked(locked0)
  );

  // Error model keyed on the delay pair currently applied by the main instance.
  always_comb begin
    acc = 18'd100;
    case (mode)
      0: acc = (sym == 8'd37 && sam == 2'd2) ? 18'd20 : 18'd100;
      1: acc = ((sym == 8'd36 && sam == 2'd1) || (sym == 8'd38 && sam == 2'd3)) ? 18'd50 : 18'd90;
      default: acc = 18'h3FFFF;
    endcase
  end

  always @(negedge clk) begin
    if (done) begin
      done_cnt <= done_cnt + 1;
      s_sam    <= sam;
      s_sym    <= sym;
      s_dat    <= dat;
      s_best   <= best;
      s_busy   <= busy;
      s_locked <= locked;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One qualifying event followed by two quiet clocks, matching the per-point cadence.
  task automatic ev();
    cycle_done = 1'b1;
    tick();
    cycle_done = 1'b0;
    start = 1'b0;
    tick();
    tick();
  endtask

  typedef struct {
    int          mode;
    bit          inject;
    logic [1:0]  sam;
    logic [7:0]  sym;
    logic [7:0]  dat;
    logic [17:0] best;
  } sweep_vec_t;

  sweep_vec_t vecs[3];

  task automatic run_sweep(input sweep_vec_t v);
    int d0;
    mode = v.mode;
    d0 = done_cnt;
    check("busy_before_start", {31'd0, busy}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("locked_cleared", {31'd0, locked}, 32'd0);
    check("first_point_sym", {24'd0, sym}, 32'd36);
    tick();
    for (int i = 0; i < 24; i++) begin
      if (i == 23) check("done_early", done_cnt - d0, 32'd0);
      if (v.inject && (i == 7 || i == 13)) start = 1'b1;
      ev();
    end
    for (int k = 0; k < 4; k++) tick();
    check("done_once", done_cnt - d0, 32'd1);
    check("final_sam", {30'd0, s_sam}, {30'd0, v.sam});
    check("final_sym", {24'd0, s_sym}, {24'd0, v.sym});
    check("final_data", {24'd0, s_dat}, {24'd0, v.dat});
    check("best_err", {14'd0, s_best}, {14'd0, v.best});
    check("locked_on_done", {31'd0, s_locked}, 32'd1);
    check("busy_on_done", {31'd0, s_busy}, 32'd0);
    check("locked_after", {31'd0, locked}, 32'd1);
  endtask

  initial begin
    int d0;
    vecs[0] = '{mode: 2, inject: 1'b0, sam: 2'd0, sym: 8'd36, dat: 8'd50, best: 18'h3FFFF};
    vecs[1] = '{mode: 1, inject: 1'b1, sam: 2'd1, sym: 8'd36, dat: 8'd50, best: 18'd50};
    vecs[2] = '{mode: 0, inject: 1'b0, sam: 2'd2, sym: 8'd37, dat: 8'd51, best: 18'd20};

    #12;
    reset = 1'b0;
    tick();
    check("rst_sam", {30'd0, sam}, 32'd1);
    check("rst_sym", {24'd0, sym}, 32'd38);
    check("rst_data", {24'd0, dat}, 32'd52);
    check("rst_best", {14'd0, best}, 32'h3FFFF);
    check("rst_busy_done_locked", {29'd0, busy, done, locked}, 32'd0);

    for (int i = 0; i < 3; i++) run_sweep(vecs[i]);

    // Abort after 5 events, coincident with a further event.
    mode = 0;
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) ev();
    check("abort_busy_pre", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    cycle_done = 1'b1;
    tick();
    abort = 1'b0;
    cycle_done = 1'b0;
    check("abort_sam", {30'd0, sam}, 32'd1);
    check("abort_sym", {24'd0, sym}, 32'd38);
    check("abort_data", {24'd0, dat}, 32'd52);
    check("abort_busy_locked", {30'd0, busy, locked}, 32'd0);
    for (int i = 0; i < 4; i++) ev();
    check("abort_no_done", done_cnt - d0, 32'd0);
    check("abort_stays_idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-sweep, away from any clock edge.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) ev();
    #2;
    reset = 1'b1;
    #1;
    check("arst_sam", {30'd0, sam}, 32'd1);
    check("arst_sym", {24'd0, sym}, 32'd38);
    check("arst_data", {24'd0, dat}, 32'd52);
    check("arst_best", {14'd0, best}, 32'h3FFFF);
    check("arst_busy_locked", {30'd0, busy, locked}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Zero-settle instance: cycle_done without sym_clk_en must not advance the point.
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    cycle_done = 1'b1;
    sym_clk_en = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("gated_sam_hold", {30'd0, sam0}, 32'd0);
    check("gated_busy", {31'd0, busy0}, 32'd1);
    sym_clk_en = 1'b1;
    tick();
    cycle_done = 1'b0;
    check("event_compare_sam", {30'd0, sam0}, 32'd0);
    tick();
    check("event_advance_sam", {30'd0, sam0}, 32'd1);
    check("event_advance_sym", {24'd0, sym0}, 32'd36);
    abort0 = 1'b1;
    tick();
    abort0 = 1'b0;
    check("abort0_sam", {30'd0, sam0}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
